if_id_buffer: RTL and testbench
===============================

Name: if_id_buffer

Overview:
- Decoupling buffer between the IF stage and the ID stage of the pipelined rv32i core.
- Captures each fetched {pc, instruction} pair from IF and presents it to ID under a valid/ready handshake.
- Lets IF keep fetching while ID stalls, and discards all wrong-path entries on a branch/jump flush.
- Implemented as a small circular FIFO with registered outputs.

Parameters:
- DEPTH, 2, number of entries; power of two, minimum 2.
- NOP_INST, 32'h00000013, instruction driven on out_inst whenever out_valid=0 (addi x0,x0,0).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- flush  input  1  discard all buffered entries and any entry offered this cycle.
- in_valid  input  1  IF offers an entry this cycle.
- in_pc  input  32  PC of offered instruction (rv32i_word).
- in_inst  input  32  offered instruction word (rv32i_word).
- in_ready  output  1  buffer accepts an entry this cycle.
- out_valid  output  1  head entry is valid for ID.
- out_pc  output  32  PC of head entry.
- out_inst  output  32  instruction of head entry; NOP_INST when out_valid=0.
- out_ready  input  1  ID consumes the head entry this cycle (ID not stalled).
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset: rst is sampled on the rising edge of clk only.
  - Sets count=0 and head/tail pointers to 0.
  - Results in out_valid=0, out_pc=0, out_inst=NOP_INST, in_ready=1.
  - Storage contents are don't-care after reset.
- Handshakes:
  - push = in_valid & in_ready & ~flush.
  - pop = out_valid & out_ready & ~flush.
- in_ready = (count < DEPTH). It depends only on registered state, not on out_ready, so there is no combinational in-to-out path.
- out_valid = (count != 0).
  - out_pc and out_inst are read from the head entry.
  - When empty: out_pc=0 and out_inst=NOP_INST.
- Latency: an entry pushed at edge N is visible on the outputs after edge N (one cycle). There is no same-cycle bypass from in_* to out_*.
- Occupancy update on each edge:
  - push only: count+1, tail advances.
  - pop only: count-1, head advances.
  - push and pop together: count unchanged, both pointers advance.
    - Legal whenever count is between 1 and DEPTH-1.
    - When full, in_ready=0, so no push occurs even if a pop occurs that cycle.
- Pointers wrap modulo DEPTH. count distinguishes full from empty.
- Ordering: strict FIFO; entries leave in the order accepted.
- Empty with out_ready=1: no pop, no state change.
- in_valid=1 while in_ready=0: entry is not accepted. IF must hold in_pc/in_inst stable until accepted.
- Flush:
  - Has highest priority after rst.
  - On the edge where flush=1: count=0, head=tail=0, no push and no pop.
  - The next cycle shows out_valid=0, out_inst=NOP_INST, in_ready=1.
  - in_ready is still driven by count during the flush cycle, but the offered entry is dropped.
- rst and flush asserted together: identical result, i.e. reset state.
- Reset mid-operation: all buffered entries are lost; no partial output.
- No X on any output after the first reset edge.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 -> count=0, out_valid=0, out_inst=32'h00000013, out_pc=0, in_ready=1.
- Pass-through: out_ready=1; push pc=0x60, inst=0x00500093, then pc=0x64, inst=0x00A00113 on consecutive cycles -> each appears on out one cycle after push, in order; count stays ≤1.
- Stall fill: out_ready=0; push 0x60, 0x64, 0x68 on consecutive cycles -> first two accepted; count=2, in_ready=0; 0x68 held by IF. Release out_ready -> outputs 0x60, 0x64, 0x68 in order, no loss or duplication.
- Simultaneous push/pop at count=1: head=0x60, push 0x64 with out_ready=1 -> count stays 1, out_pc=0x64 next cycle.
- Flush: with count=2 (0x60, 0x64), assert flush with in_valid=1 (pc=0x68) and out_ready=1 -> next cycle count=0, out_valid=0, out_inst=NOP; 0x68 is not later output. Push pc=0x100 -> out_pc=0x100 one cycle later.
- Wrap-around: 10 pushes with random out_ready stalls -> all 10 PCs emerge in order; count never exceeds 2.

Source files
------------

// File: rtl/if_id_buffer.sv
// if_id_buffer
//   Decoupling FIFO between the IF and ID stages of the rv32i pipeline.
//   Each accepted {pc, instruction} pair is held in a small circular buffer
//   and presented to ID under a valid/ready handshake. A flush drops every
//   buffered entry, and also drops the entry offered in the same cycle.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   flush      discard all entries, including the one offered this cycle
//   in_valid   IF offers {in_pc, in_inst}
//   in_pc      PC of the offered instruction
//   in_inst    offered instruction word
//   in_ready   buffer has room (depends on registered occupancy only)
//   out_valid  head entry valid for ID
//   out_pc     PC of head entry, 0 when empty
//   out_inst   instruction of head entry, NOP_INST when empty
//   out_ready  ID consumes the head entry this cycle
//   count      current occupancy, 0..DEPTH
module if_id_buffer #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_inst,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_inst,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      pc_mem_q   [DEPTH];
  logic [31:0]      pc_mem_d   [DEPTH];
  logic [31:0]      inst_mem_q [DEPTH];
  logic [31:0]      inst_mem_d [DEPTH];

  logic push;
  logic pop;

  // Status comes straight from registered occupancy, so in_ready never
  // depends combinationally on out_ready.
  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign out_pc    = out_valid ? pc_mem_q[head_q]   : 32'h0;
  assign out_inst  = out_valid ? inst_mem_q[head_q] : NOP_INST;
  assign count     = count_q;

  assign push = in_valid  & in_ready  & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;

    if (push) begin
      pc_mem_d[tail_q]   = in_pc;
      inst_mem_d[tail_q] = in_inst;
      tail_d             = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Flush wins over any handshake; storage is left as-is since the
    // pointers and count make it unreachable.
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: it is only read while count is nonzero.
  always_ff @(posedge clk) begin
    pc_mem_q   <= pc_mem_d;
    inst_mem_q <= inst_mem_d;
  end

endmodule

// File: tb/tb_if_id_buffer.sv
module tb_if_id_buffer;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_pc, in_inst, out_pc, out_inst;
  logic        in_ready, out_valid;
  logic [1:0]  count;

  int checks   = 0;
  int failures = 0;

  if_id_buffer #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] popped[$];
  bit          live = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue updated from the sampled handshake rules.
  always @(posedge clk) begin
    int  sz;
    bit  p, q;
    sz = mq.size();
    if (rst || flush) begin
      mq.delete();
    end else begin
      p = in_valid && (sz < DEPTH);
      q = (sz != 0) && out_ready;
      if (q) begin
        popped.push_back(mq[0].pc);
        void'(mq.pop_front());
      end
      if (p) mq.push_back({in_pc, in_inst});
    end
    if (rst) live = 1;
  end

  always @(negedge clk) begin
    if (live) begin
      chk("count",     32'(count),     32'(mq.size()));
      chk("in_ready",  32'(in_ready),  32'(mq.size() < DEPTH));
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("out_pc",    out_pc,   (mq.size() != 0) ? mq[0].pc   : 32'h0);
      chk("out_inst",  out_inst, (mq.size() != 0) ? mq[0].inst : NOP);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] inst, input bit rdy);
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = rdy;
  endtask

  task automatic drain(input string nm);
    int n;
    in_valid  = 0;
    out_ready = 1;
    n = 0;
    while (out_valid && n < 20) begin
      step();
      n++;
    end
    chk({nm, "_drained"}, 32'(out_valid), 32'h0);
  endtask

  initial begin
    logic [31:0] exp_pcs[$];
    int          accepted;
    bit          acc;

    rst = 1; flush = 0;
    drive(1, 32'h60, 32'h0050_0093, 0);
    step(); step();
    chk("rst_count",     32'(count),     32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_inst",  out_inst,       32'h0000_0013);
    chk("rst_out_pc",    out_pc,         32'h0);
    chk("rst_in_ready",  32'(in_ready),  32'h1);
    rst = 0;

    // pass-through
    drive(1, 32'h60, 32'h0050_0093, 1);
    step();
    chk("pt_pc0",   out_pc,   32'h60);
    chk("pt_inst0", out_inst, 32'h0050_0093);
    drive(1, 32'h64, 32'h00A0_0113, 1);
    step();
    chk("pt_pc1",   out_pc,   32'h64);
    chk("pt_inst1", out_inst, 32'h00A0_0113);
    chk("pt_count", 32'(count), 32'h1);
    drain("pt");

    // stall fill; IF holds 0x68 until accepted
    popped.delete();
    drive(1, 32'h60, 32'h1, 0); step();
    drive(1, 32'h64, 32'h2, 0); step();
    drive(1, 32'h68, 32'h3, 0); step();
    chk("fill_count",    32'(count),    32'h2);
    chk("fill_in_ready", 32'(in_ready), 32'h0);
    chk("fill_head",     out_pc,        32'h60);
    out_ready = 1; step();
    chk("fill_rel_pc", out_pc, 32'h64);
    step();
    chk("fill_rel_pc2", out_pc, 32'h68);
    drain("fill");
    chk("fill_npop", 32'(popped.size()), 32'h3);
    if (popped.size() == 3) begin
      chk("fill_ord0", popped[0], 32'h60);
      chk("fill_ord1", popped[1], 32'h64);
      chk("fill_ord2", popped[2], 32'h68);
    end

    // simultaneous push/pop at count=1
    drive(1, 32'h60, 32'h11, 0); step();
    drive(1, 32'h64, 32'h22, 1); step();
    chk("pp_count", 32'(count), 32'h1);
    chk("pp_pc",    out_pc,     32'h64);
    drain("pp");

    // flush with a concurrent offer
    popped.delete();
    drive(1, 32'h60, 32'h1, 0); step();
    drive(1, 32'h64, 32'h2, 0); step();
    flush = 1;
    drive(1, 32'h68, 32'h3, 1); step();
    flush = 0;
    chk("fl_count",     32'(count),     32'h0);
    chk("fl_out_valid", 32'(out_valid), 32'h0);
    chk("fl_out_inst",  out_inst,       NOP);
    chk("fl_in_ready",  32'(in_ready),  32'h1);
    drive(0, 32'h0, 32'h0, 1); step();
    chk("fl_no_68", 32'(out_valid), 32'h0);
    drive(1, 32'h100, 32'h0000_0033, 1); step();
    chk("fl_pc100", out_pc, 32'h100);
    drain("fl");
    chk("fl_npop", 32'(popped.size()), 32'h1);

    // wrap-around: 10 pushes with random stalls
    popped.delete();
    exp_pcs.delete();
    accepted = 0;
    drive(1, 32'h200, $urandom, ($urandom_range(0, 2) != 0));
    for (int c = 0; c < 200 && accepted < 10; c++) begin
      acc = in_valid && in_ready;
      step();
      if (acc) begin
        exp_pcs.push_back(in_pc);
        accepted++;
        in_pc   = 32'h200 + 32'(4 * accepted);
        in_inst = $urandom;
      end
      in_valid  = (accepted < 10);
      out_ready = ($urandom_range(0, 2) != 0);
    end
    chk("wrap_accepted", 32'(accepted), 32'd10);
    drain("wrap");
    chk("wrap_npop", 32'(popped.size()), 32'd10);
    for (int i = 0; i < 10 && i < popped.size() && i < exp_pcs.size(); i++)
      chk("wrap_order", popped[i], 32'h200 + 32'(4 * i));

    // random soak with flushes and resets; the model checks every cycle
    drive(1, $urandom, $urandom, 0);
    for (int c = 0; c < 1500; c++) begin
      acc = in_valid && in_ready && !flush && !rst;
      flush     = ($urandom_range(0, 29) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      out_ready = ($urandom_range(0, 1) != 0);
      step();
      if (acc || !in_valid || flush || rst) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_pc    = $urandom;
        in_inst  = $urandom;
      end
    end
    rst = 0; flush = 0;
    drain("soak");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
